// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: elastic stereo sample buffer feeding the sigma-delta DAC.
// Samples are {right[15:0], left[15:0]}. Output stays off until the buffer
// primes to START_LEVEL. After that the DAC is always fed: silence (zero)
// is substituted on underrun, and the underruns are counted.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-low reset
//   enable_i, flush_i         playback enable, discard buffered samples
//   inport_t*                 sample stream in (valid/ready)
//   outport_t*                sample stream out to DAC (valid/ready)
//   level_o, low_water_o      occupancy and low-watermark flag
//   running_o                 playback active
//   underrun_o                one-cycle pulse per silence transfer
//   underrun_count_o          saturating silence-transfer count
module audio_sample_fifo #(
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned ADDR_W        = 6,
  parameter int unsigned START_LEVEL   = 32,
  parameter int unsigned LOW_LEVEL     = 8,
  parameter int unsigned REPRIME_COUNT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              inport_tvalid_i,
  input  logic [31:0]       inport_tdata_i,
  output logic              inport_tready_o,
  output logic              outport_tvalid_o,
  output logic [31:0]       outport_tdata_o,
  input  logic              outport_tready_i,
  output logic [ADDR_W:0]   level_o,
  output logic              low_water_o,
  output logic              running_o,
  output logic              underrun_o,
  output logic [15:0]       underrun_count_o
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned SIL_W = $clog2(REPRIME_COUNT + 1);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   level_q, level_d;
  logic [SIL_W-1:0]   sil_q, sil_d;
  logic [CNT_W-1:0]   ucnt_q, ucnt_d;
  logic               underrun_q, underrun_d;

  logic [31:0]        mem_q [DEPTH];

  logic full_c, empty_c, in_run_c, tready_c;
  logic push_c, pop_c, silence_c, reprime_c;

  // Handshake qualification; flush suppresses every transfer in its cycle
  assign full_c    = (level_q == PTR_W'(DEPTH));
  assign empty_c   = (level_q == '0);
  assign in_run_c  = (state_q == ST_RUN);
  assign tready_c  = rst_i && !flush_i && !full_c;
  assign push_c    = inport_tvalid_i && tready_c;
  assign pop_c     = rst_i && !flush_i && in_run_c && !empty_c && outport_tready_i;
  assign silence_c = rst_i && !flush_i && in_run_c && empty_c && outport_tready_i;
  assign reprime_c = silence_c && ((sil_q + SIL_W'(1)) == SIL_W'(REPRIME_COUNT));

  // Sample storage; contents need no reset
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= inport_tdata_i;
    end
  end

  // Next-state: pointers, level, silence tracking and playback FSM
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    sil_d      = sil_q;
    ucnt_d     = ucnt_q;
    underrun_d = 1'b0;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // A silence transfer never moves the level
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + PTR_W'(1);
      2'b01:   level_d = level_q - PTR_W'(1);
      default: level_d = level_q;
    endcase

    if (pop_c) sil_d = '0;

    if (silence_c) begin
      underrun_d = 1'b1;
      if (ucnt_q != {CNT_W{1'b1}}) ucnt_d = ucnt_q + CNT_W'(1);
      sil_d = reprime_c ? '0 : sil_q + SIL_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (!enable_i)                             state_d = ST_IDLE;
        else if (level_q >= PTR_W'(START_LEVEL))   state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable_i)      state_d = ST_IDLE;
        else if (reprime_c) state_d = ST_PRIME;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush empties the buffer but keeps the underrun statistic
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      sil_d    = '0;
      state_d  = enable_i ? ST_PRIME : ST_IDLE;
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sil_q      <= '0;
      ucnt_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sil_q      <= sil_d;
      ucnt_q     <= ucnt_d;
      underrun_q <= underrun_d;
    end
  end

  // Outputs are forced low while reset is held, before the first edge too
  assign inport_tready_o  = tready_c;
  assign outport_tvalid_o = rst_i && in_run_c;
  assign outport_tdata_o  = (rst_i && in_run_c && !empty_c) ? mem_q[rd_ptr_q[ADDR_W-1:0]] : '0;
  assign level_o          = rst_i ? level_q : '0;
  assign low_water_o      = rst_i && (level_q < PTR_W'(LOW_LEVEL));
  assign running_o        = rst_i && in_run_c;
  assign underrun_o       = rst_i && underrun_q;
  assign underrun_count_o = rst_i ? ucnt_q : '0;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: priming, backpressure, underrun and
// reprime, flush, mid-run reset, and underrun counter saturation.
module tb_audio_sample_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, flush, tv, tr;
  logic [31:0] td;
  logic        tready, tvalid, low_w, running, und;
  logic [31:0] tdata;
  logic [6:0]  level;
  logic [15:0] ucnt;

  logic        en2, tv2, tr2;
  logic [31:0] td2;
  logic        tready2, tvalid2, low_w2, running2, und2;
  logic [31:0] tdata2;
  logic [6:0]  level2;
  logic [15:0] ucnt2;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] q[$];
  int          lvl;

  always #5 clk = ~clk;

  audio_sample_fifo u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .flush_i(flush),
    .inport_tvalid_i(tv), .inport_tdata_i(td), .inport_tready_o(tready),
    .outport_tvalid_o(tvalid), .outport_tdata_o(tdata), .outport_tready_i(tr),
    .level_o(level), .low_water_o(low_w), .running_o(running),
    .underrun_o(und), .underrun_count_o(ucnt)
  );

  audio_sample_fifo #(.REPRIME_COUNT(32'hFFFFF)) u_sat (
    .clk_i(clk), .rst_i(rst), .enable_i(en2), .flush_i(1'b0),
    .inport_tvalid_i(tv2), .inport_tdata_i(td2), .inport_tready_o(tready2),
    .outport_tvalid_o(tvalid2), .outport_tdata_o(tdata2), .outport_tready_i(tr2),
    .level_o(level2), .low_water_o(low_w2), .running_o(running2),
    .underrun_o(und2), .underrun_count_o(ucnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] samp(input int i);
    logic [31:0] v;
    if (i == 31) v = 32'h0001_0002;
    else         v = {16'(16'h1000 + i), 16'(16'h2000 + i)};
    return v;
  endfunction

  task automatic test_reset();
    logic [59:0] all;
    rst = 1'b0; en = 1'b0; flush = 1'b0; tv = 1'b0; tr = 1'b0; td = '0;
    en2 = 1'b0; tv2 = 1'b0; tr2 = 1'b0; td2 = '0;
    tick(); tick();
    all = {tready, tvalid, tdata, level, low_w, running, und, ucnt};
    n_checks++;
    if (all !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", all); end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({tready, low_w, running, tvalid, level} !== {1'b1, 1'b1, 1'b0, 1'b0, 7'd0}) begin
      n_fail++; $display("FAIL reset_release got rdy=%b low=%b run=%b vld=%b lvl=%0d exp 1 1 0 0 0",
                         tready, low_w, running, tvalid, level);
    end
  endtask

  task automatic test_prime();
    en = 1'b1;
    tick();
    for (int i = 0; i < 31; i++) begin
      tv = 1'b1; td = samp(i); q.push_back(td);
      tick();
    end
    n_checks++;
    if ({running, tvalid, level} !== {1'b0, 1'b0, 7'd31}) begin
      n_fail++; $display("FAIL prime_31 got run=%b vld=%b lvl=%0d exp 0 0 31", running, tvalid, level);
    end
    td = samp(31); q.push_back(td);
    tick();
    tv = 1'b0;
    n_checks++;
    if ({running, level} !== {1'b0, 7'd32}) begin
      n_fail++; $display("FAIL prime_32_edge got run=%b lvl=%0d exp 0 32", running, level);
    end
    tick();
    n_checks++;
    if ({running, tvalid, level, tdata} !== {1'b1, 1'b1, 7'd32, 32'h1000_2000}) begin
      n_fail++; $display("FAIL prime_run got run=%b vld=%b lvl=%0d data=%h exp 1 1 32 10002000",
                         running, tvalid, level, tdata);
    end
    lvl = 32;
  endtask

  task automatic test_backpressure();
    int   pushed = 0;
    int   k = 0;
    logic exp_rdy, pop, saw_full = 1'b0, saw_reject = 1'b0;
    while (pushed < 64 && k < 400) begin
      tv = 1'b1; td = 32'hA000_0000 + 32'(pushed); tr = ((k % 4) == 3);
      #1;
      exp_rdy = (lvl != 64);
      n_checks++;
      if (tready !== exp_rdy || level !== 7'(lvl) || tvalid !== 1'b1) begin
        n_fail++; $display("FAIL bp_cycle%0d got rdy=%b lvl=%0d vld=%b exp %b %0d 1",
                           k, tready, level, tvalid, exp_rdy, lvl);
      end
      pop = tr && (lvl != 0);
      if (pop) begin
        n_checks++;
        if (tdata !== q[0]) begin n_fail++; $display("FAIL bp_data got=%h exp=%h", tdata, q[0]); end
      end
      if (!exp_rdy) saw_full = 1'b1;
      if (!exp_rdy && tr) saw_reject = 1'b1;
      if (pop) void'(q.pop_front());
      if (exp_rdy) begin q.push_back(td); pushed++; lvl++; end
      if (pop) lvl--;
      tick();
      k++;
    end
    tv = 1'b0; tr = 1'b0;
    n_checks++;
    if (k >= 400) begin n_fail++; $display("FAIL bp_timeout got pushed=%0d exp 64", pushed); end
    n_checks++;
    if ({saw_full, saw_reject} !== 2'b11) begin
      n_fail++; $display("FAIL bp_full_reject got full=%b reject=%b exp 1 1", saw_full, saw_reject);
    end
  endtask

  task automatic test_underrun();
    int k = 0;
    while (lvl > 0 && k < 200) begin
      tr = 1'b1;
      #1;
      n_checks++;
      if (tdata !== q[0] || level !== 7'(lvl)) begin
        n_fail++; $display("FAIL drain_data got=%h lvl=%0d exp=%h %0d", tdata, level, q[0], lvl);
      end
      void'(q.pop_front()); lvl--;
      tick();
      k++;
    end
    tr = 1'b0;
    #1;
    n_checks++;
    if ({level, tvalid, tdata, ucnt} !== {7'd0, 1'b1, 32'd0, 16'd0}) begin
      n_fail++; $display("FAIL drained got lvl=%0d vld=%b data=%h cnt=%0d exp 0 1 0 0", level, tvalid, tdata, ucnt);
    end
    for (int p = 1; p <= 3; p++) begin
      tr = 1'b1;
      #1;
      n_checks++;
      if ({tvalid, tdata} !== {1'b1, 32'd0}) begin
        n_fail++; $display("FAIL silence_out got vld=%b data=%h exp 1 0", tvalid, tdata);
      end
      tick();
      tr = 1'b0;
      n_checks++;
      if ({und, ucnt, running} !== {1'b1, 16'(p), 1'b1}) begin
        n_fail++; $display("FAIL underrun_%0d got und=%b cnt=%0d run=%b exp 1 %0d 1", p, und, ucnt, running, p);
      end
      tick();
      n_checks++;
      if (und !== 1'b0) begin n_fail++; $display("FAIL underrun_pulse_%0d got=%b exp=0", p, und); end
    end
    tr = 1'b1;
    tick();
    tr = 1'b0;
    n_checks++;
    if ({running, tvalid, ucnt, und} !== {1'b0, 1'b0, 16'd4, 1'b1}) begin
      n_fail++; $display("FAIL reprime got run=%b vld=%b cnt=%0d und=%b exp 0 0 4 1", running, tvalid, ucnt, und);
    end
    tick();
  endtask

  task automatic test_flush();
    for (int n = 0; n < 20; n++) begin
      tv = 1'b1; td = 32'hC000_0000 + 32'(n);
      tick();
      n_checks++;
      if ({level, low_w} !== {7'(n + 1), (n + 1) < 8}) begin
        n_fail++; $display("FAIL fill_lw got lvl=%0d low=%b exp %0d %b", level, low_w, n + 1, (n + 1) < 8);
      end
    end
    flush = 1'b1; td = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({tready, level} !== {1'b0, 7'd20}) begin
      n_fail++; $display("FAIL flush_rdy got rdy=%b lvl=%0d exp 0 20", tready, level);
    end
    tick();
    flush = 1'b0; tv = 1'b0;
    #1;
    n_checks++;
    if ({level, running, tvalid, ucnt, low_w} !== {7'd0, 1'b0, 1'b0, 16'd4, 1'b1}) begin
      n_fail++; $display("FAIL flush_after got lvl=%0d run=%b vld=%b cnt=%0d low=%b exp 0 0 0 4 1",
                         level, running, tvalid, ucnt, low_w);
    end
    for (int n = 0; n < 32; n++) begin
      tv = 1'b1; td = 32'hE000_0000 + 32'(n);
      tick();
    end
    tv = 1'b0;
    tick();
    n_checks++;
    if ({running, tdata} !== {1'b1, 32'hE000_0000}) begin
      n_fail++; $display("FAIL flush_refill got run=%b data=%h exp 1 e0000000", running, tdata);
    end
    for (int j = 0; j < 22; j++) begin
      tr = 1'b1;
      #1;
      n_checks++;
      if (tdata !== 32'hE000_0000 + 32'(j)) begin
        n_fail++; $display("FAIL refill_data got=%h exp=%h", tdata, 32'hE000_0000 + 32'(j));
      end
      tick();
    end
    tr = 1'b0;
    n_checks++;
    if (level !== 7'd10) begin n_fail++; $display("FAIL level_10 got=%0d exp=10", level); end
  endtask

  task automatic test_midrun_reset();
    logic [59:0] all;
    rst = 1'b0; tv = 1'b1; td = 32'h1234_5678; tr = 1'b1;
    #1;
    all = {tready, tvalid, tdata, level, low_w, running, und, ucnt};
    n_checks++;
    if (all !== '0) begin n_fail++; $display("FAIL rst_comb got=%h exp=0", all); end
    tick();
    all = {tready, tvalid, tdata, level, low_w, running, und, ucnt};
    n_checks++;
    if (all !== '0) begin n_fail++; $display("FAIL rst_held got=%h exp=0", all); end
    rst = 1'b1; tv = 1'b0; tr = 1'b0; en = 1'b0;
    tick();
    n_checks++;
    if ({level, running, ucnt, tready, tvalid} !== {7'd0, 1'b0, 16'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rst_release got lvl=%0d run=%b cnt=%0d rdy=%b vld=%b exp 0 0 0 1 0",
                         level, running, ucnt, tready, tvalid);
    end
  endtask

  task automatic test_saturate();
    en2 = 1'b1;
    tick();
    for (int n = 0; n < 32; n++) begin
      tv2 = 1'b1; td2 = 32'h5000_0000 + 32'(n);
      tick();
    end
    tv2 = 1'b0;
    tick();
    n_checks++;
    if ({running2, tdata2, level2} !== {1'b1, 32'h5000_0000, 7'd32}) begin
      n_fail++; $display("FAIL sat_run got run=%b data=%h lvl=%0d exp 1 50000000 32", running2, tdata2, level2);
    end
    tr2 = 1'b1;
    for (int n = 0; n < 32; n++) tick();
    n_checks++;
    if ({level2, ucnt2, tvalid2, tdata2, low_w2, tready2} !== {7'd0, 16'd0, 1'b1, 32'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL sat_empty got lvl=%0d cnt=%0d vld=%b data=%h low=%b rdy=%b exp 0 0 1 0 1 1",
                         level2, ucnt2, tvalid2, tdata2, low_w2, tready2);
    end
    for (int n = 0; n < 65534; n++) tick();
    n_checks++;
    if (ucnt2 !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe got=%h exp=fffe", ucnt2); end
    tick();
    n_checks++;
    if (ucnt2 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff got=%h exp=ffff", ucnt2); end
    for (int n = 0; n < 4465; n++) tick();
    n_checks++;
    if ({ucnt2, und2, running2} !== {16'hFFFF, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL sat_hold got cnt=%h und=%b run=%b exp ffff 1 1", ucnt2, und2, running2);
    end
    tr2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prime();
    test_backpressure();
    test_underrun();
    test_flush();
    test_midrun_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
